// File: rtl/mips8_pkg.sv
// Shared definitions for the 8-bit MIPS datapath.
// Covers instruction field positions, opcodes and the fetch-stage state encoding.
package mips8_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [PC_W-1:0] RESET_PC = 8'h00;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_LW    = 4'h2;
  localparam logic [3:0] OP_SW    = 4'h3;
  localparam logic [3:0] OP_BEQ   = 4'h4;
  localparam logic [3:0] OP_J     = 4'h5;
  localparam logic [3:0] HALT_OP  = 4'hF;

  // Field positions within the 16-bit instruction word
  localparam int OP_HI    = 15;
  localparam int OP_LO    = 12;
  localparam int RS_HI    = 11;
  localparam int RS_LO    = 9;
  localparam int RT_HI    = 8;
  localparam int RT_LO    = 6;
  localparam int RD_HI    = 5;
  localparam int RD_LO    = 3;
  localparam int FUNCT_HI = 2;
  localparam int FUNCT_LO = 0;
  localparam int IMM_HI   = 5;
  localparam int IMM_LO   = 0;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/if_stage_ir_fields.sv
// Combinational splitter of an instruction word into its decode fields.
// Kept separate so a later decode stage can reuse it.
module ir_fields
  import mips8_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [2:0]         rs,
  output logic [2:0]         rt,
  output logic [2:0]         rd,
  output logic [2:0]         funct,
  output logic [5:0]         imm6
);

  assign opcode = ir[OP_HI:OP_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign funct  = ir[FUNCT_HI:FUNCT_LO];
  assign imm6   = ir[IMM_HI:IMM_LO];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, imem req/ack handshake, IR with valid/ready to decode.
// Redirect beats everything except reset; HALT stops fetching until a redirect.
module if_stage
  import mips8_pkg::*;
#(
  parameter int              PC_W     = mips8_pkg::PC_W,
  parameter int              INSTR_W  = mips8_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = mips8_pkg::RESET_PC,
  parameter logic [3:0]      HALT_OP  = mips8_pkg::HALT_OP
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [PC_W-1:0]    ir_pc,
  output logic [PC_W-1:0]    ir_pc_plus1,
  output logic [3:0]         opcode,
  output logic [2:0]         rs,
  output logic [2:0]         rt,
  output logic [2:0]         rd,
  output logic [2:0]         funct,
  output logic [5:0]         imm6,
  output logic               halted
);

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    ir_pc_q, ir_pc_d;

  ir_fields u_ir_fields (
    .ir     (ir_q),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .funct  (funct),
    .imm6   (imm6)
  );

  // An ack is only honoured in a cycle where a request is actually issued,
  // which also drops acks during reset, redirect, halt and backpressure.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    ir_pc_d  = ir_pc_q;
    imem_req = 1'b0;
    if (rst) begin
      imem_req = 1'b0;
    end else if (redirect_valid) begin
      state_d = FETCH;
      pc_d    = redirect_pc;
    end else begin
      case (state_q)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_d    = imem_rdata;
            ir_pc_d = pc_q;
            pc_d    = pc_q + PC_W'(1);
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            if (opcode == HALT_OP) begin
              state_d = HALTED;
            end else begin
              imem_req = 1'b1;
              if (imem_ack) begin
                ir_d    = imem_rdata;
                ir_pc_d = pc_q;
                pc_d    = pc_q + PC_W'(1);
              end else begin
                state_d = FETCH;
              end
            end
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      ir_pc_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ir_valid    = (state_q == HOLD);
  assign halted      = (state_q == HALTED);
  assign ir_pc       = ir_pc_q;
  assign ir_pc_plus1 = ir_pc_q + PC_W'(1);

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: streaming, backpressure, wrap, redirect, halt, slow memory.
// Inputs change 1 time unit after each rising edge; outputs are checked 1 unit later.
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  ir_pc;
  logic [7:0]  ir_pc_plus1;
  logic [3:0]  opcode;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [2:0]  rd;
  logic [2:0]  funct;
  logic [5:0]  imm6;
  logic        halted;

  int checks = 0;
  int fails  = 0;

  if_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_pc          (ir_pc),
    .ir_pc_plus1    (ir_pc_plus1),
    .opcode         (opcode),
    .rs             (rs),
    .rt             (rt),
    .rd             (rd),
    .funct          (funct),
    .imm6           (imm6),
    .halted         (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    redirect_valid = 1'b0; redirect_pc = 8'h00; ir_ready = 1'b1;
    tick(); tick();
    #1;
    checks++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (ir_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid got=%0b exp=0", ir_valid); end
    checks++; if (halted !== 1'b0) begin fails++; $display("[TB] FAIL reset_halted got=%0b exp=0", halted); end
    checks++; if (ir_pc !== 8'h00) begin fails++; $display("[TB] FAIL reset_ir_pc got=%h exp=00", ir_pc); end
    checks++; if (opcode !== 4'h0) begin fails++; $display("[TB] FAIL reset_opcode got=%h exp=0", opcode); end
    rst = 1'b0; imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin fails++; $display("[TB] FAIL reset_first_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 8'h00) begin fails++; $display("[TB] FAIL reset_first_addr got=%h exp=00", imem_addr); end
  endtask

  // ack every cycle, decode always ready: one instruction per cycle
  task automatic test_stream();
    logic [15:0] word;
    tick();
    imem_ack = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      word = 16'h1000 + 16'(i);
      imem_rdata = word;
      #1;
      checks++; if (imem_req !== 1'b1) begin fails++; $display("[TB] FAIL stream_req[%0d] got=%0b exp=1", i, imem_req); end
      checks++; if (imem_addr !== 8'(i)) begin fails++; $display("[TB] FAIL stream_addr[%0d] got=%h exp=%h", i, imem_addr, 8'(i)); end
      tick();
      checks++; if (ir_valid !== 1'b1) begin fails++; $display("[TB] FAIL stream_valid[%0d] got=%0b exp=1", i, ir_valid); end
      checks++; if (ir_pc !== 8'(i)) begin fails++; $display("[TB] FAIL stream_ir_pc[%0d] got=%h exp=%h", i, ir_pc, 8'(i)); end
      checks++; if (ir_pc_plus1 !== 8'(i + 1)) begin fails++; $display("[TB] FAIL stream_plus1[%0d] got=%h exp=%h", i, ir_pc_plus1, 8'(i + 1)); end
      checks++; if (opcode !== 4'h1) begin fails++; $display("[TB] FAIL stream_opcode[%0d] got=%h exp=1", i, opcode); end
      checks++; if (imm6 !== word[5:0]) begin fails++; $display("[TB] FAIL stream_imm6[%0d] got=%h exp=%h", i, imm6, word[5:0]); end
    end
  endtask

  task automatic test_backpressure();
    imem_ack = 1'b1; ir_ready = 1'b1; imem_rdata = 16'hA5C7;
    tick();
    checks++; if (ir_pc !== 8'h06) begin fails++; $display("[TB] FAIL bp_ir_pc got=%h exp=06", ir_pc); end
    ir_ready = 1'b0; imem_rdata = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL bp_req[%0d] got=%0b exp=0", i, imem_req); end
      checks++; if (ir_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_valid[%0d] got=%0b exp=1", i, ir_valid); end
      checks++; if (opcode !== 4'hA) begin fails++; $display("[TB] FAIL bp_opcode[%0d] got=%h exp=a", i, opcode); end
      checks++; if (rs !== 3'd2) begin fails++; $display("[TB] FAIL bp_rs[%0d] got=%0d exp=2", i, rs); end
      checks++; if (rt !== 3'd7) begin fails++; $display("[TB] FAIL bp_rt[%0d] got=%0d exp=7", i, rt); end
      checks++; if (rd !== 3'd0) begin fails++; $display("[TB] FAIL bp_rd[%0d] got=%0d exp=0", i, rd); end
      checks++; if (funct !== 3'd7) begin fails++; $display("[TB] FAIL bp_funct[%0d] got=%0d exp=7", i, funct); end
      checks++; if (imm6 !== 6'h07) begin fails++; $display("[TB] FAIL bp_imm6[%0d] got=%h exp=07", i, imm6); end
      tick();
    end
    ir_ready = 1'b1; imem_ack = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) begin fails++; $display("[TB] FAIL bp_release_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 8'h07) begin fails++; $display("[TB] FAIL bp_release_addr got=%h exp=07", imem_addr); end
    tick();
    checks++; if (ir_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_after_valid got=%0b exp=0", ir_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [3];
    exp_pc[0] = 8'hFE; exp_pc[1] = 8'hFF; exp_pc[2] = 8'h00;
    redirect_valid = 1'b1; redirect_pc = 8'hFE; imem_ack = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL wrap_redirect_req got=%0b exp=0", imem_req); end
    tick();
    redirect_valid = 1'b0; ir_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_rdata = 16'h1000 + 16'(exp_pc[i]);
      #1;
      checks++; if (imem_addr !== exp_pc[i]) begin fails++; $display("[TB] FAIL wrap_addr[%0d] got=%h exp=%h", i, imem_addr, exp_pc[i]); end
      tick();
      checks++; if (ir_pc !== exp_pc[i]) begin fails++; $display("[TB] FAIL wrap_ir_pc[%0d] got=%h exp=%h", i, ir_pc, exp_pc[i]); end
      if (i == 1) begin
        checks++; if (ir_pc_plus1 !== 8'h00) begin fails++; $display("[TB] FAIL wrap_plus1 got=%h exp=00", ir_pc_plus1); end
      end
    end
  endtask

  task automatic test_redirect_ack();
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h05;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 8'h05) begin fails++; $display("[TB] FAIL redir_pending_addr got=%h exp=05", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 16'h7777; redirect_valid = 1'b1; redirect_pc = 8'h40;
    #1;
    checks++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL redir_req got=%0b exp=0", imem_req); end
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b0;
    #1;
    checks++; if (ir_valid !== 1'b0) begin fails++; $display("[TB] FAIL redir_valid got=%0b exp=0", ir_valid); end
    checks++; if (ir_pc !== 8'h00) begin fails++; $display("[TB] FAIL redir_ir_pc got=%h exp=00", ir_pc); end
    checks++; if (imem_req !== 1'b1) begin fails++; $display("[TB] FAIL redir_next_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 8'h40) begin fails++; $display("[TB] FAIL redir_next_addr got=%h exp=40", imem_addr); end
  endtask

  task automatic test_halt();
    redirect_valid = 1'b1; redirect_pc = 8'h10; imem_ack = 1'b0;
    tick();
    redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hF000; ir_ready = 1'b0;
    tick();
    checks++; if (opcode !== 4'hF) begin fails++; $display("[TB] FAIL halt_opcode got=%h exp=f", opcode); end
    checks++; if (ir_pc !== 8'h10) begin fails++; $display("[TB] FAIL halt_ir_pc got=%h exp=10", ir_pc); end
    imem_ack = 1'b0; ir_ready = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL halt_consume_req got=%0b exp=0", imem_req); end
    tick();
    imem_ack = 1'b1; imem_rdata = 16'h2222;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (halted !== 1'b1) begin fails++; $display("[TB] FAIL halt_flag[%0d] got=%0b exp=1", i, halted); end
      checks++; if (imem_req !== 1'b0) begin fails++; $display("[TB] FAIL halt_req[%0d] got=%0b exp=0", i, imem_req); end
      checks++; if (ir_valid !== 1'b0) begin fails++; $display("[TB] FAIL halt_valid[%0d] got=%0b exp=0", i, ir_valid); end
      tick();
    end
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h20;
    tick();
    redirect_valid = 1'b0;
    #1;
    checks++; if (halted !== 1'b0) begin fails++; $display("[TB] FAIL unhalt_flag got=%0b exp=0", halted); end
    checks++; if (imem_req !== 1'b1) begin fails++; $display("[TB] FAIL unhalt_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 8'h20) begin fails++; $display("[TB] FAIL unhalt_addr got=%h exp=20", imem_addr); end
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick();
    checks++; if (ir_pc !== 8'h20) begin fails++; $display("[TB] FAIL unhalt_ir_pc got=%h exp=20", ir_pc); end
    checks++; if (ir_valid !== 1'b1) begin fails++; $display("[TB] FAIL unhalt_valid got=%0b exp=1", ir_valid); end
  endtask

  task automatic test_slow_memory();
    imem_ack = 1'b0; ir_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (imem_req !== 1'b1) begin fails++; $display("[TB] FAIL slow_req[%0d] got=%0b exp=1", i, imem_req); end
      checks++; if (imem_addr !== 8'h21) begin fails++; $display("[TB] FAIL slow_addr[%0d] got=%h exp=21", i, imem_addr); end
      tick();
    end
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h33; imem_ack = 1'b1; imem_rdata = 16'h5555;
    tick();
    rst = 1'b0; redirect_valid = 1'b0; imem_ack = 1'b0;
    #1;
    checks++; if (imem_addr !== 8'h00) begin fails++; $display("[TB] FAIL slow_rst_pc got=%h exp=00", imem_addr); end
    checks++; if (ir_valid !== 1'b0) begin fails++; $display("[TB] FAIL slow_rst_valid got=%0b exp=0", ir_valid); end
    checks++; if (ir_pc !== 8'h00) begin fails++; $display("[TB] FAIL slow_rst_ir_pc got=%h exp=00", ir_pc); end
    checks++; if (imem_req !== 1'b1) begin fails++; $display("[TB] FAIL slow_rst_req got=%0b exp=1", imem_req); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_wrap();
    test_redirect_ack();
    test_halt();
    test_slow_memory();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the 8-bit MIPS datapath. It sits directly upstream of the immediate extender and the decode/register-file stage.
- Holds the PC and requests 16-bit instructions from instruction memory over a req/ack handshake.
- Latches each fetched instruction into the IR and presents its decoded fields downstream under a valid/ready handshake: opcode, rs, rt, rd, funct, and the 6-bit immediate consumed by the extender.
- Supports PC redirect (branch/jump) and a HALT opcode.

Parameters:
- PC_W, 8, PC and instruction-memory address width (word-addressed).
- INSTR_W, 16, instruction width.
- RESET_PC, 8'h00, PC value after reset.
- HALT_OP, 4'hF, opcode that stops fetching.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; held until ack.
- imem_addr  out  PC_W  fetch address (= pc); stable while imem_req=1.
- imem_ack  in  1  memory accepts the request; imem_rdata is valid in the same cycle.
- imem_rdata  in  INSTR_W  fetched instruction.
- redirect_valid  in  1  load a new PC (taken branch/jump).
- redirect_pc  in  PC_W  target PC.
- ir_valid  out  1  IR holds an instruction for decode.
- ir_ready  in  1  decode consumes the IR this cycle.
- ir_pc  out  PC_W  address of the instruction in the IR.
- ir_pc_plus1  out  PC_W  ir_pc+1 (mod 256); branch base.
- opcode  out  4  IR[15:12].
- rs  out  3  IR[11:9].
- rt  out  3  IR[8:6].
- rd  out  3  IR[5:3].
- funct  out  3  IR[2:0].
- imm6  out  6  IR[5:0]; feeds the extender din.
- halted  out  1  fetch stopped by HALT.

Behaviour:
- Reset (rst=1 at a rising edge):
  - pc=RESET_PC, ir=16'h0000, ir_pc=0.
  - ir_valid=0, halted=0, state=FETCH.
  - imem_req=0 during the reset cycle.
- The field outputs are pure slices of the IR register; they are only meaningful while ir_valid=1.
- States:
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, go to HOLD with these register updates:
    - ir <= imem_rdata
    - ir_pc <= pc
    - pc <= pc+1 (8-bit wrap, 8'hFF -> 8'h00)
    - ir_valid <= 1
  - HOLD: ir_valid=1.
    - If ir_ready=1 and the IR opcode != HALT_OP: go to FETCH and start the next request in the same cycle (imem_req=1 asserted combinationally).
    - Back-to-back rule: if ir_ready=1 and imem_ack=1 in the same cycle, the IR reloads directly and the state stays HOLD. Peak throughput is therefore 1 instruction/cycle.
    - If ir_ready=1 and the opcode == HALT_OP: go to HALTED; ir_valid<=0; halted<=1.
    - If ir_ready=0: the IR and all fields are held stable and imem_req=0.
  - HALTED: imem_req=0, ir_valid=0, halted=1. Exits only on rst or redirect_valid.
- Redirect has the highest priority, in any state:
  - pc <= redirect_pc; ir_valid <= 0; halted <= 0; state <= FETCH.
  - Any imem_ack arriving in the same cycle is discarded: its data is not latched and pc does not increment.
  - imem_req is forced to 0 in the redirect cycle, so no stale address is issued.
- Same-cycle priority when rst and redirect_valid are both high: rst wins.
- Latency:
  - One cycle from imem_ack to ir_valid=1.
  - After a redirect, the first new request is issued the following cycle.
- imem_addr must not change while imem_req=1 and imem_ack=0.
- No outstanding transactions exist: a request completes in its ack cycle.

Decomposition:
- Shared package `mips8_pkg`:
  - opcode localparams, including HALT_OP;
  - field bit positions (OP_HI/LO, RS, RT, RD, FUNCT, IMM);
  - PC_W and INSTR_W;
  - fetch state encoding (FETCH, HOLD, HALTED).
- One natural sub-module, `ir_fields`: a combinational IR field splitter, shared with any later decode stage.
- The PC/FSM logic stays in if_stage.

Test Plan:
- Reset, then imem_ack=1 every cycle with rdata = addr-dependent pattern (16'h1000+addr), ir_ready=1:
  - ir_pc runs 0,1,2,…;
  - ir_valid is continuous from cycle 2;
  - imm6 = rdata[5:0].
- Backpressure: ir_ready=0 for 5 cycles while holding 16'hA5C7:
  - opcode=A, rs=2, rt=7, imm6=6'h07 stable;
  - imem_req=0;
  - on release, the next fetch addr = ir_pc+1.
- Wrap: redirect_pc=8'hFE, then fetch 3 instructions:
  - ir_pc sequence FE, FF, 00;
  - ir_pc_plus1 for FF is 00.
- Redirect coincident with imem_ack (addr 8'h05, target 8'h40):
  - the ack data is not latched and ir_valid=0 next cycle;
  - the next request has imem_addr=8'h40.
- HALT: fetch 16'hF000 at 8'h10 and consume it:
  - halted=1, imem_req stays 0 for 10 cycles;
  - redirect to 8'h20 clears halted and fetches 8'h20.
- Slow memory: imem_ack delayed 3 cycles:
  - imem_addr stays constant;
  - a rst pulse mid-wait returns pc=RESET_PC and ir_valid=0.
